// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station.
// Holds the bus widths, the opcodes the testbench and ALU agree on, the entry
// layout, and the operand snoop helper used on both stored and dispatched operands.
package alu_rs_pkg;

  localparam int unsigned OP_LEN      = 6;
  localparam int unsigned IMM_LEN     = 32;
  localparam int unsigned PC_LEN      = 32;
  localparam int unsigned ROB_LEN     = 4;
  localparam int unsigned INT_LEN     = 32;
  localparam int unsigned DATA_LEN    = 32;
  localparam int unsigned RS_SIZE_DEF = 16;

  localparam logic [OP_LEN-1:0] OpAdd = 6'd0;
  localparam logic [OP_LEN-1:0] OpSub = 6'd1;
  localparam logic [OP_LEN-1:0] OpAnd = 6'd2;
  localparam logic [OP_LEN-1:0] OpOr  = 6'd3;
  localparam logic [OP_LEN-1:0] OpXor = 6'd4;

  // One source operand: busy=1 means the value is still owed by ROB entry 'tag'.
  typedef struct packed {
    logic                busy;
    logic [ROB_LEN-1:0]  tag;
    logic [DATA_LEN-1:0] val;
  } operand_t;

  typedef struct packed {
    logic               busy;
    logic [OP_LEN-1:0]  op;
    logic [IMM_LEN-1:0] imm;
    logic [PC_LEN-1:0]  pc;
    logic [ROB_LEN-1:0] robpos;
    operand_t           opnd1;
    operand_t           opnd2;
  } rs_entry_t;

  // Registered issue bundle presented to the ALU.
  typedef struct packed {
    logic [OP_LEN-1:0]  op;
    logic [IMM_LEN-1:0] imm;
    logic [PC_LEN-1:0]  pc;
    logic [ROB_LEN-1:0] robpos;
    logic [INT_LEN-1:0] rs1;
    logic [INT_LEN-1:0] rs2;
  } issue_t;

  // Resolve a pending operand against the two result buses; ALU bus wins a tie.
  function automatic operand_t snoop(operand_t o,
                                     logic alu_flag, logic [ROB_LEN-1:0] alu_tag,
                                     logic [DATA_LEN-1:0] alu_val,
                                     logic lsb_flag, logic [ROB_LEN-1:0] lsb_tag,
                                     logic [DATA_LEN-1:0] lsb_val);
    operand_t r;
    r = o;
    if (o.busy) begin
      if (alu_flag && (o.tag == alu_tag)) begin
        r.busy = 1'b0;
        r.val  = alu_val;
      end else if (lsb_flag && (o.tag == lsb_tag)) begin
        r.busy = 1'b0;
        r.val  = lsb_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index one-hot picker.
// req_i   : request vector
// found_o : at least one request set
// idx_o   : index of the lowest set bit (0 when none)
module alu_rs_pick #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]         req_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Walk downwards so the last hit written is the lowest index.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = $clog2(N)'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station.
// Buffers dispatched ALU ops until both operands are known, snooping the ALU
// and LSB result buses, and issues the lowest-index ready entry each cycle.
// clk_i/rst_ni       : clock, async active-low reset
// ready_i            : global stall (0 holds everything)
// clear_i            : flush all entries
// issue_*_i          : dispatch port with operand tags/values
// alu_*_i, lsb_*_i   : result broadcast buses
// work_o..rs2_o      : registered issue to the ALU
// rs_full_o          : no free entry this cycle
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ready_i,
  input  logic                clear_i,
  input  logic                issue_valid_i,
  input  logic [OP_LEN-1:0]   issue_op_i,
  input  logic [IMM_LEN-1:0]  issue_imm_i,
  input  logic [PC_LEN-1:0]   issue_pc_i,
  input  logic [ROB_LEN-1:0]  issue_robpos_i,
  input  logic                issue_q1_busy_i,
  input  logic [ROB_LEN-1:0]  issue_q1_i,
  input  logic [DATA_LEN-1:0] issue_v1_i,
  input  logic                issue_q2_busy_i,
  input  logic [ROB_LEN-1:0]  issue_q2_i,
  input  logic [DATA_LEN-1:0] issue_v2_i,
  input  logic                alu_flag_i,
  input  logic [ROB_LEN-1:0]  alu_robpos_i,
  input  logic [DATA_LEN-1:0] alu_val_i,
  input  logic                lsb_flag_i,
  input  logic [ROB_LEN-1:0]  lsb_robpos_i,
  input  logic [DATA_LEN-1:0] lsb_val_i,
  output logic                work_o,
  output logic [OP_LEN-1:0]   op_o,
  output logic [IMM_LEN-1:0]  imm_o,
  output logic [PC_LEN-1:0]   pc_o,
  output logic [ROB_LEN-1:0]  robpos_o,
  output logic [INT_LEN-1:0]  rs1_o,
  output logic [INT_LEN-1:0]  rs2_o,
  output logic                rs_full_o
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  rs_entry_t        ent_q [RS_SIZE];
  rs_entry_t        ent_d [RS_SIZE];
  rs_entry_t        new_ent;
  issue_t           out_q, out_d;
  logic             work_q, work_d;
  logic [RS_SIZE-1:0] free_vec, rdy_vec;
  logic             free_found, rdy_found;
  logic [IdxW-1:0]  free_idx, rdy_idx;

  // Both vectors come from the state at cycle start, so a slot freed by this
  // edge's issue is not reusable until the next edge, and a new entry cannot
  // issue on the edge that writes it.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i] = ~ent_q[i].busy;
      rdy_vec[i]  = ent_q[i].busy & ~ent_q[i].opnd1.busy & ~ent_q[i].opnd2.busy;
    end
  end

  alu_rs_pick #(.N(RS_SIZE)) u_pick_free (
    .req_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  alu_rs_pick #(.N(RS_SIZE)) u_pick_rdy (
    .req_i   (rdy_vec),
    .found_o (rdy_found),
    .idx_o   (rdy_idx)
  );

  assign rs_full_o = ~free_found;

  // Dispatched operands also snoop this cycle's broadcasts so a result on the
  // bus right now is not missed.
  always_comb begin
    new_ent        = '0;
    new_ent.busy   = 1'b1;
    new_ent.op     = issue_op_i;
    new_ent.imm    = issue_imm_i;
    new_ent.pc     = issue_pc_i;
    new_ent.robpos = issue_robpos_i;
    new_ent.opnd1  = snoop(operand_t'{busy: issue_q1_busy_i, tag: issue_q1_i, val: issue_v1_i},
                           alu_flag_i, alu_robpos_i, alu_val_i,
                           lsb_flag_i, lsb_robpos_i, lsb_val_i);
    new_ent.opnd2  = snoop(operand_t'{busy: issue_q2_busy_i, tag: issue_q2_i, val: issue_v2_i},
                           alu_flag_i, alu_robpos_i, alu_val_i,
                           lsb_flag_i, lsb_robpos_i, lsb_val_i);
  end

  always_comb begin
    ent_d  = ent_q;
    out_d  = out_q;
    work_d = work_q;
    if (ready_i) begin
      if (clear_i) begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          ent_d[i].busy = 1'b0;
        end
        work_d = 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          ent_d[i].opnd1 = snoop(ent_q[i].opnd1, alu_flag_i, alu_robpos_i, alu_val_i,
                                 lsb_flag_i, lsb_robpos_i, lsb_val_i);
          ent_d[i].opnd2 = snoop(ent_q[i].opnd2, alu_flag_i, alu_robpos_i, alu_val_i,
                                 lsb_flag_i, lsb_robpos_i, lsb_val_i);
        end
        work_d = rdy_found;
        if (rdy_found) begin
          out_d.op            = ent_q[rdy_idx].op;
          out_d.imm           = ent_q[rdy_idx].imm;
          out_d.pc            = ent_q[rdy_idx].pc;
          out_d.robpos        = ent_q[rdy_idx].robpos;
          out_d.rs1           = ent_q[rdy_idx].opnd1.val;
          out_d.rs2           = ent_q[rdy_idx].opnd2.val;
          ent_d[rdy_idx].busy = 1'b0;
        end
        if (issue_valid_i && free_found) begin
          ent_d[free_idx] = new_ent;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      out_q  <= '0;
      work_q <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      out_q  <= out_d;
      work_q <= work_d;
    end
  end

  assign work_o   = work_q;
  assign op_o     = out_q.op;
  assign imm_o    = out_q.imm;
  assign pc_o     = out_q.pc;
  assign robpos_o = out_q.robpos;
  assign rs1_o    = out_q.rs1;
  assign rs2_o    = out_q.rs2;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: expected issues are queued as stimulus is
// driven and compared by a monitor whenever the station presents a new issue.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk_i = 1'b0, rst_ni = 1'b0, ready_i = 1'b1, clear_i = 1'b0;
  logic issue_valid_i = 1'b0;
  logic [5:0] issue_op_i = '0;
  logic [31:0] issue_imm_i = '0, issue_pc_i = '0, issue_v1_i = '0, issue_v2_i = '0;
  logic [3:0] issue_robpos_i = '0, issue_q1_i = '0, issue_q2_i = '0;
  logic issue_q1_busy_i = 1'b0, issue_q2_busy_i = 1'b0;
  logic alu_flag_i = 1'b0, lsb_flag_i = 1'b0;
  logic [3:0] alu_robpos_i = '0, lsb_robpos_i = '0;
  logic [31:0] alu_val_i = '0, lsb_val_i = '0;
  logic work_o, rs_full_o;
  logic [5:0] op_o;
  logic [31:0] imm_o, pc_o, rs1_o, rs2_o;
  logic [3:0] robpos_o;

  alu_rs #(.RS_SIZE(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ready_i(ready_i), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i), .issue_imm_i(issue_imm_i),
    .issue_pc_i(issue_pc_i), .issue_robpos_i(issue_robpos_i),
    .issue_q1_busy_i(issue_q1_busy_i), .issue_q1_i(issue_q1_i), .issue_v1_i(issue_v1_i),
    .issue_q2_busy_i(issue_q2_busy_i), .issue_q2_i(issue_q2_i), .issue_v2_i(issue_v2_i),
    .alu_flag_i(alu_flag_i), .alu_robpos_i(alu_robpos_i), .alu_val_i(alu_val_i),
    .lsb_flag_i(lsb_flag_i), .lsb_robpos_i(lsb_robpos_i), .lsb_val_i(lsb_val_i),
    .work_o(work_o), .op_o(op_o), .imm_o(imm_o), .pc_o(pc_o), .robpos_o(robpos_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rs_full_o(rs_full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic rdy_edge = 1'b0;

  // A fresh issue exists only after an edge at which the station was not stalled.
  always @(posedge clk_i) rdy_edge <= ready_i;

  always @(negedge clk_i) begin
    if (rst_ni && rdy_edge && work_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue got robpos=%0d op=%h rs1=%h rs2=%h (nothing expected)",
                 robpos_o, op_o, rs1_o, rs2_o);
      end else begin
        mon_e = sb.pop_front();
        if ({op_o, imm_o, pc_o, robpos_o, rs1_o, rs2_o} !== mon_e) begin
          errors++;
          $display("FAIL issue_fields got op=%h imm=%h pc=%h rob=%0d rs1=%h rs2=%h exp op=%h imm=%h pc=%h rob=%0d rs1=%h rs2=%h",
                   op_o, imm_o, pc_o, robpos_o, rs1_o, rs2_o,
                   mon_e.op, mon_e.imm, mon_e.pc, mon_e.rob, mon_e.rs1, mon_e.rs2);
        end
      end
    end
  end

  task automatic set_issue(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [3:0] rob, input logic q1b, input logic [3:0] q1,
                           input logic [31:0] v1, input logic q2b, input logic [3:0] q2,
                           input logic [31:0] v2);
    issue_op_i = op; issue_imm_i = imm; issue_pc_i = pc; issue_robpos_i = rob;
    issue_q1_busy_i = q1b; issue_q1_i = q1; issue_v1_i = v1;
    issue_q2_busy_i = q2b; issue_q2_i = q2; issue_v2_i = v2;
    issue_valid_i = 1'b1;
  endtask

  // Presents one dispatch for exactly one edge; returns 1 ns after that edge.
  task automatic dispatch(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] rob, input logic q1b, input logic [3:0] q1,
                          input logic [31:0] v1, input logic q2b, input logic [3:0] q2,
                          input logic [31:0] v2);
    @(negedge clk_i);
    set_issue(op, imm, pc, rob, q1b, q1, v1, q2b, q2, v2);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_clear();
    @(negedge clk_i); clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL reset_work got %b exp 0", work_o); end
    checks++;
    if (rs_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", rs_full_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_add();
    sb.push_back(exp_t'{OpAdd, 32'h0, 32'h100, 4'd3, 32'd5, 32'd7});
    dispatch(OpAdd, 32'h0, 32'h100, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL add_latency got work=%b exp 0", work_o); end
    step();
    checks++;
    if (work_o !== 1'b1) begin errors++; $display("FAIL add_issue got work=%b exp 1", work_o); end
    step();
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL add_drain got work=%b exp 0", work_o); end
  endtask

  task automatic test_alu_wakeup();
    dispatch(OpSub, 32'd4, 32'h200, 4'd1, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (work_o !== 1'b0) begin errors++; $display("FAIL sub_wait got work=%b exp 0", work_o); end
    end
    sb.push_back(exp_t'{OpSub, 32'd4, 32'h200, 4'd1, 32'd10, 32'd1});
    @(negedge clk_i);
    alu_flag_i = 1'b1; alu_robpos_i = 4'd6; alu_val_i = 32'd10;
    @(posedge clk_i); #1; alu_flag_i = 1'b0;
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL wake_same_edge got work=%b exp 0", work_o); end
    step();
    checks++;
    if (work_o !== 1'b1 || robpos_o !== 4'd1) begin
      errors++; $display("FAIL wake_issue got work=%b rob=%0d exp 1/1", work_o, robpos_o);
    end
  endtask

  task automatic test_same_cycle_lsb();
    sb.push_back(exp_t'{OpOr, 32'h0, 32'h300, 4'd2, 32'd3, 32'h80});
    @(negedge clk_i);
    set_issue(OpOr, 32'h0, 32'h300, 4'd2, 1'b0, 4'd0, 32'd3, 1'b1, 4'd9, 32'd0);
    lsb_flag_i = 1'b1; lsb_robpos_i = 4'd9; lsb_val_i = 32'h80;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; lsb_flag_i = 1'b0;
    step();
    checks++;
    if (work_o !== 1'b1 || rs2_o !== 32'h80) begin
      errors++; $display("FAIL lsb_bypass got work=%b rs2=%h exp 1/80", work_o, rs2_o);
    end
    step();
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL lsb_drain got work=%b exp 0", work_o); end
  endtask

  task automatic test_full();
    logic [5:0] op;
    for (int i = 0; i < 16; i++) begin
      op = (i == 4) ? 6'h3F : OpAnd;  // entry 4 carries a non-ALU opcode
      dispatch(op, 32'(i), 32'h400 + 32'(i * 4), 4'(i), 1'b1, 4'(i), 32'd0,
               1'b0, 4'd0, 32'(i + 100));
      if (i == 14) begin
        checks++;
        if (rs_full_o !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", rs_full_o); end
      end
    end
    checks++;
    if (rs_full_o !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", rs_full_o); end
    // Would issue next edge if it were wrongly accepted.
    dispatch(OpAdd, 32'h0, 32'h999, 4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    sb.push_back(exp_t'{6'h3F, 32'd4, 32'h410, 4'd4, 32'h44, 32'd104});
    @(negedge clk_i);
    alu_flag_i = 1'b1; alu_robpos_i = 4'd4; alu_val_i = 32'h44;
    @(posedge clk_i); #1; alu_flag_i = 1'b0;
    checks++;
    if (rs_full_o !== 1'b1) begin errors++; $display("FAIL full_hold got %b exp 1", rs_full_o); end
    step();
    checks++;
    if (work_o !== 1'b1 || rs_full_o !== 1'b0) begin
      errors++; $display("FAIL full_release got work=%b full=%b exp 1/0", work_o, rs_full_o);
    end
    do_clear();
    checks++;
    if (rs_full_o !== 1'b0 || work_o !== 1'b0) begin
      errors++; $display("FAIL full_clear got full=%b work=%b exp 0/0", rs_full_o, work_o);
    end
  endtask

  task automatic test_clear_overrides();
    for (int i = 0; i < 6; i++) begin
      dispatch(OpXor, 32'd0, 32'h500, 4'(i), 1'b1, 4'(10 + i), 32'd0, 1'b0, 4'd0, 32'd0);
    end
    // Resolved entry that would issue on the clearing edge.
    dispatch(OpAdd, 32'd0, 32'h600, 4'd7, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    do_clear();
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL clear_issue got work=%b exp 0", work_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      alu_flag_i = 1'b1; alu_robpos_i = 4'(10 + 2 * c); alu_val_i = 32'd1;
      lsb_flag_i = 1'b1; lsb_robpos_i = 4'(11 + 2 * c); lsb_val_i = 32'd2;
      step();
    end
    alu_flag_i = 1'b0; lsb_flag_i = 1'b0;
    step();
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL clear_stale got work=%b exp 0", work_o); end
  endtask

  task automatic test_hold();
    dispatch(OpAdd, 32'd0, 32'h700, 4'd8, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0);
    sb.push_back(exp_t'{OpAdd, 32'd1, 32'h704, 4'd9, 32'h11, 32'h22});
    dispatch(OpAdd, 32'd1, 32'h704, 4'd9, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
    dispatch(OpSub, 32'd2, 32'h708, 4'd10, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44);
    @(negedge clk_i);
    ready_i = 1'b0;
    set_issue(OpAnd, 32'd3, 32'h70C, 4'd11, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd6);
    alu_flag_i = 1'b1; alu_robpos_i = 4'd5; alu_val_i = 32'h55;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (work_o !== 1'b1 || robpos_o !== 4'd9 || rs1_o !== 32'h11) begin
        errors++;
        $display("FAIL stall_hold got work=%b rob=%0d rs1=%h exp 1/9/11", work_o, robpos_o, rs1_o);
      end
    end
    @(negedge clk_i);
    ready_i = 1'b1; issue_valid_i = 1'b0; alu_flag_i = 1'b0;
    sb.push_back(exp_t'{OpSub, 32'd2, 32'h708, 4'd10, 32'h33, 32'h44});
    step();
    checks++;
    if (work_o !== 1'b1 || robpos_o !== 4'd10) begin
      errors++; $display("FAIL stall_resume got work=%b rob=%0d exp 1/10", work_o, robpos_o);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (work_o !== 1'b0) begin errors++; $display("FAIL stall_ignored got work=%b exp 0", work_o); end
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    dispatch(OpAdd, 32'd0, 32'h800, 4'd12, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
    sb.push_back(exp_t'{OpAdd, 32'd0, 32'h804, 4'd13, 32'd1, 32'd2});
    dispatch(OpAdd, 32'd0, 32'h804, 4'd13, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    dispatch(OpAdd, 32'd0, 32'h808, 4'd14, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4);
    step();
    checks++;
    if (work_o !== 1'b1 || robpos_o !== 4'd14) begin
      errors++; $display("FAIL pre_reset got work=%b rob=%0d exp 1/14", work_o, robpos_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (work_o !== 1'b0 || rs_full_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got work=%b full=%b exp 0/0", work_o, rs_full_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.push_back(exp_t'{OpXor, 32'd9, 32'h900, 4'd15, 32'hA, 32'hB});
    set_issue(OpXor, 32'd9, 32'h900, 4'd15, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hB);
    alu_flag_i = 1'b1; alu_robpos_i = 4'd2; alu_val_i = 32'hDEAD;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; alu_flag_i = 1'b0;
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL post_reset_lat got work=%b exp 0", work_o); end
    step();
    checks++;
    if (work_o !== 1'b1 || robpos_o !== 4'd15) begin
      errors++; $display("FAIL post_reset_issue got work=%b rob=%0d exp 1/15", work_o, robpos_o);
    end
    step();
    checks++;
    if (work_o !== 1'b0) begin errors++; $display("FAIL reset_discard got work=%b exp 0", work_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_wakeup();
    test_same_cycle_lsb();
    test_full();
    test_clear_overrides();
    test_hold();
    test_async_reset();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16, number of station entries (power of two, 2..32).
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL have ready  input  1  global stall; 0 freezes all state and outputs.
REQ-005 SHALL have clear  input  1  synchronous mispredict flush.
REQ-006 SHALL have dispatch inputs: issue_valid 1, issue_op OP_LEN (6), issue_imm 32, issue_pc 32, issue_robpos ROB_LEN (4).
REQ-007 SHALL have operand inputs: issue_q1_busy 1, issue_q1 ROB_LEN, issue_v1 32, issue_q2_busy 1, issue_q2 ROB_LEN, issue_v2 32; busy=1 means value pending on that ROB tag.
REQ-008 SHALL have snoop inputs: alu_flag 1, alu_robpos ROB_LEN, alu_val 32, lsb_flag 1, lsb_robpos ROB_LEN, lsb_val 32.
REQ-009 SHALL have outputs to ALU: work 1, op OP_LEN, imm 32, pc 32, robpos ROB_LEN, rs1 32, rs2 32, all registered.
REQ-010 SHALL have rs_full  output  1  combinational, no free entry.

Function
REQ-011 Each entry SHALL hold busy, op, imm, pc, robpos, q1_busy, q1, v1, q2_busy, q2, v2.
REQ-012 When ready=1, clear=0, issue_valid=1, rs_full=0, SHALL write dispatch into lowest-index free entry at the edge.
REQ-013 Dispatch while rs_full=1 SHALL be ignored with no state change.
REQ-014 Dispatched operand with busy=1 whose tag equals a same-cycle alu or lsb broadcast SHALL be stored as resolved with the broadcast value.
REQ-015 Each edge (ready=1, clear=0), every stored pending operand matching alu_robpos (alu_flag=1) or lsb_robpos (lsb_flag=1) SHALL capture the value and clear its busy; alu takes priority if both match (not expected).
REQ-016 Entry is ready when busy=1, q1_busy=0, q2_busy=0 at cycle start.
REQ-017 Each edge SHALL select the lowest-index ready entry, drive its fields onto outputs, set work=1, free the entry; no ready entry sets work=0.
REQ-018 Minimum latency: entry dispatched with both operands resolved at edge N SHALL appear with work=1 after edge N+1; entry woken by broadcast at edge N SHALL issue at edge N+1 at earliest.
REQ-019 A slot freed at edge N SHALL not be reused by dispatch at edge N; a slot written at edge N SHALL not issue at edge N.
REQ-020 At most one issue and one dispatch per cycle; rs_full SHALL reflect occupancy before the edge.
REQ-021 ready=0 SHALL hold every register, ignore dispatch and broadcasts.
REQ-022 clear=1 (with ready=1) SHALL invalidate all entries and set work=0 at that edge, overriding dispatch and issue.
REQ-023 op values outside the ALU opcode set SHALL be issued unchanged; filtering is the ALU's job.

Reset
REQ-024 reset=0 SHALL immediately clear all entry busy bits and set work=0; other output values undefined-but-stable (0 preferred).
REQ-025 Reset asserted mid-operation SHALL discard all entries; first dispatch accepted on first edge after deassertion.

Structure
REQ-026 OP codes, OP_LEN, IMM_LEN, PC_LEN, ROB_LEN, INT_LEN, DATA_LEN SHALL come from the shared definitions file; RS_SIZE default SHALL also be defined there.
REQ-027 Lowest-index selection (free slot and ready slot) SHALL use one sub-module alu_rs_pick, instantiated twice.

Verification
REQ-028 Dispatch ADD v1=5 v2=7 both resolved, robpos=3 -> next edge work=1, op=ADD, rs1=5, rs2=7, robpos=3; following edge work=0.
REQ-029 Dispatch SUB q1 busy tag 6, v2=1; two cycles later alu_flag=1 alu_robpos=6 alu_val=10 -> issue next edge with rs1=10, rs2=1.
REQ-030 Dispatch with q2 tag 9 in the same cycle lsb_flag=1 lsb_robpos=9 lsb_val=0x80 -> issues next edge with rs2=0x80.
REQ-031 Fill 16 pending entries -> rs_full=1, 17th dispatch ignored; wake entry 4 -> issues, rs_full=0 next cycle.
REQ-032 Six pending entries plus clear=1 -> all freed, work=0, broadcasts to old tags cause no issue; ready=0 for 3 cycles mid-run -> outputs unchanged.
REQ-033 reset=0 asynchronously mid-run -> work=0 without a clock edge, rs_full=0.
